neosd_blk_reader: RTL

//  Wishbone master that sequences one single-block SD read (CMD17) through the neosd slave registers.

---
 rtl/neosd_blk_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/neosd_blk_reader.sv
// neosd_blk_reader
// Wishbone master that runs one single-block SD read (CMD17) through the
// neosd slave registers. It computes the command CRC7, commits the command,
// polls the IRQ flags, captures the R1 response and streams the data words
// out over a valid/ready interface.

module neosd_blk_reader #(
    parameter int          WORDS    = 128,
    parameter logic [1:0]  DMODE_RD = 2'b01,
    parameter logic [1:0]  RMODE_R1 = 2'b01,
    parameter int          TMO_W    = 20
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [31:0] blk_addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o,
    output logic [31:0] resp_o,
    output logic [31:0] m_dat_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int WCNT_W = $clog2(WORDS) + 1;

    localparam logic [31:0] ADR_STAT   = 32'h0000_0004;
    localparam logic [31:0] ADR_IRQ    = 32'h0000_0008;
    localparam logic [31:0] ADR_CMDARG = 32'h0000_0010;
    localparam logic [31:0] ADR_CMD    = 32'h0000_0014;
    localparam logic [31:0] ADR_RESP   = 32'h0000_0018;
    localparam logic [31:0] ADR_DATA   = 32'h0000_001C;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_TMO = 2'd1;
    localparam logic [1:0] ERR_CRC = 2'd2;
    localparam logic [1:0] ERR_BUS = 2'd3;

    localparam logic [5:0]        CMD_IDX   = 6'd17;
    localparam logic [5:0]        CRC_LAST  = 6'd39;
    localparam logic [TMO_W-1:0]  TMO_MAX   = '1;
    localparam logic [WCNT_W-1:0] WCNT_MAX  = '1;
    localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CRC,
        S_WR_ARG,
        S_CLR,
        S_WR_CMD,
        S_POLL_R,
        S_RD_RESP,
        S_POLL_D,
        S_RD_DAT,
        S_PUSH,
        S_CHK,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]       arg_q;
    logic [39:0]       crc_sh_q;
    logic [6:0]        crc_q;
    logic [6:0]        crc_next;
    logic [5:0]        bitcnt_q;
    logic              clr_step_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              tmo_sat;
    logic [WCNT_W-1:0] wcnt_q;
    logic [1:0]        err_q;
    logic [31:0]       cmd_word;

    logic              acc_end;
    logic              issue;
    logic [31:0]       iss_adr;
    logic [31:0]       iss_dat;
    logic              iss_we;

    assign acc_end  = wb_cyc_o & (wb_ack_i | wb_err_i);
    assign tmo_sat  = (tmo_q == TMO_MAX);
    assign cmd_word = {10'd0, CMD_IDX, 1'b0, crc_q, 2'b00, RMODE_R1, DMODE_RD, 1'b1, 1'b1};

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign m_valid_o = (state_q == S_PUSH);
    assign err_o     = err_q;
    assign wb_sel_o  = wb_cyc_o ? 4'hF : 4'h0;

    // One CRC7 step: the next frame bit enters MSB-first, x^7 + x^3 + 1
    always_comb begin
        logic fb;
        fb       = crc_sh_q[39] ^ crc_q[6];
        crc_next = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bus request decode; a new access is only issued once the previous cycle has closed
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        iss_adr = 32'd0;
        iss_dat = 32'd0;
        iss_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CRC;
                end
            end
            S_CRC: begin
                if (bitcnt_q == CRC_LAST) begin
                    state_d = S_WR_ARG;
                end
            end
            S_WR_ARG: begin
                iss_adr = ADR_CMDARG;
                iss_dat = arg_q;
                iss_we  = 1'b1;
                if (acc_end) begin
                    state_d = S_CLR;
                end else begin
                    issue = ~wb_cyc_o;
                end
            end
            S_CLR: begin
                iss_adr = clr_step_q ? ADR_IRQ : ADR_STAT;
                iss_we  = 1'b1;
                if (acc_end) begin
                    if (clr_step_q) begin
                        state_d = S_WR_CMD;
                    end
                end else begin
                    issue = ~wb_cyc_o;
                end
            end
            S_WR_CMD: begin
                iss_adr = ADR_CMD;
                iss_dat = cmd_word;
                iss_we  = 1'b1;
                if (acc_end) begin
                    state_d = S_POLL_R;
                end else begin
                    issue = ~wb_cyc_o;
                end
            end
            S_POLL_R: begin
                iss_adr = ADR_IRQ;
                if (acc_end) begin
                    if (wb_dat_i[1]) begin
                        state_d = S_RD_RESP;
                    end
                end else if (!wb_cyc_o) begin
                    if (tmo_sat) begin
                        state_d = S_DONE;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_RD_RESP: begin
                iss_adr = ADR_RESP;
                if (acc_end) begin
                    state_d = S_POLL_D;
                end else begin
                    issue = ~wb_cyc_o;
                end
            end
            S_POLL_D: begin
                iss_adr = ADR_IRQ;
                if (acc_end) begin
                    if (wb_dat_i[3]) begin
                        state_d = S_RD_DAT;
                    end else if (wb_dat_i[2]) begin
                        state_d = S_CHK;
                    end
                end else if (!wb_cyc_o) begin
                    if (tmo_sat) begin
                        state_d = S_DONE;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_RD_DAT: begin
                iss_adr = ADR_DATA;
                if (acc_end) begin
                    state_d = S_PUSH;
                end else begin
                    issue = ~wb_cyc_o;
                end
            end
            S_PUSH: begin
                if (m_ready_i) begin
                    state_d = S_POLL_D;
                end
            end
            S_CHK: begin
                iss_adr = ADR_STAT;
                if (acc_end) begin
                    state_d = S_DONE;
                end else begin
                    issue = ~wb_cyc_o;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (acc_end && wb_err_i) begin
            state_d = S_DONE;
        end
    end

    // Wishbone signalling: strobe lasts the single cycle after a request, cycle holds until ack/err
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_adr_o <= 32'd0;
            wb_dat_o <= 32'd0;
            wb_we_o  <= 1'b0;
        end else begin
            wb_stb_o <= issue;
            if (issue) begin
                wb_cyc_o <= 1'b1;
                wb_adr_o <= iss_adr;
                wb_dat_o <= iss_dat;
                wb_we_o  <= iss_we;
            end else if (acc_end) begin
                wb_cyc_o <= 1'b0;
            end
        end
    end

    // Sequence datapath: argument, CRC shifter, counters, captured response/data and status
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            arg_q      <= 32'd0;
            crc_sh_q   <= 40'd0;
            crc_q      <= 7'd0;
            bitcnt_q   <= 6'd0;
            clr_step_q <= 1'b0;
            tmo_q      <= '0;
            wcnt_q     <= '0;
            err_q      <= ERR_OK;
            resp_o     <= 32'd0;
            m_dat_o    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        arg_q      <= blk_addr_i;
                        crc_sh_q   <= {2'b01, CMD_IDX, blk_addr_i};
                        crc_q      <= 7'd0;
                        bitcnt_q   <= 6'd0;
                        clr_step_q <= 1'b0;
                        err_q      <= ERR_OK;
                    end
                end
                S_CRC: begin
                    crc_q    <= crc_next;
                    crc_sh_q <= {crc_sh_q[38:0], 1'b0};
                    bitcnt_q <= bitcnt_q + 6'd1;
                end
                S_CLR: begin
                    if (acc_end && !wb_err_i) begin
                        clr_step_q <= 1'b1;
                    end
                end
                S_WR_CMD: begin
                    if (acc_end) begin
                        tmo_q <= '0;
                    end
                end
                S_POLL_R, S_POLL_D: begin
                    if (!tmo_sat) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                    if (!wb_cyc_o && tmo_sat) begin
                        err_q <= ERR_TMO;
                    end
                end
                S_RD_RESP: begin
                    if (acc_end && !wb_err_i) begin
                        resp_o <= wb_dat_i;
                        wcnt_q <= '0;
                        tmo_q  <= '0;
                    end
                end
                S_RD_DAT: begin
                    if (acc_end && !wb_err_i) begin
                        m_dat_o <= wb_dat_i;
                        tmo_q   <= '0;
                        if (wcnt_q != WCNT_MAX) begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                S_PUSH: begin
                    if (m_ready_i) begin
                        tmo_q <= '0;
                    end
                end
                S_CHK: begin
                    if (acc_end && !wb_err_i) begin
                        err_q <= (wb_dat_i[2] || (wcnt_q != WCNT_FULL)) ? ERR_CRC : ERR_OK;
                    end
                end
                default: begin
                end
            endcase
            if (acc_end && wb_err_i) begin
                err_q <= ERR_BUS;
            end
        end
    end

endmodule
